// File: rtl/legv8_control_fsm_if.sv
// Control-port bundle between the LEGv8 multi-cycle control unit (slave) and the
// datapath/ROM side that feeds it instructions and status (master).
interface legv8_control_fsm_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      instr;
    logic [4:0]       status_sig;
    logic [30:0]      controlWord;
    logic [63:0]      K;
    logic             halted;
    logic [CNT_W-1:0] retired;

    modport master (
        output instr,
        output status_sig,
        input  controlWord,
        input  K,
        input  halted,
        input  retired
    );

    modport slave (
        input  instr,
        input  status_sig,
        output controlWord,
        output K,
        output halted,
        output retired
    );
endinterface

// File: rtl/legv8_control_fsm.sv
// Multi-cycle LEGv8 control unit: FETCH/EXEC/WB/HALT sequencer that decodes the latched IR
// into the datapath control word. Defining LEGV8_MOVZ_EN adds MOVZ decode.
module legv8_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    legv8_control_fsm_if.slave bus
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WB    = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDS, OP_SUBS,
        OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI,
        OP_STUR, OP_LDUR, OP_B, OP_BL, OP_BR,
        OP_CBZ, OP_CBNZ, OP_BCOND, OP_MOVZ, OP_BAD
    } op_e;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01011;

    state_e           state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    op_e              op_s;

    logic [4:0]  da_s, sa_s, sb_s, fs_s;
    logic        bsel_s, asel_s, reg_write_s, mem_write_s, status_load_s;
    logic        en_b_s, en_alu_s, en_mem_s, en_pc_s;
    logic [1:0]  ps_s;
    logic [63:0] k_s;

    logic [4:0]  rd_s, rn_s, rm_s;
    logic [63:0] imm12_s, imm9_s, br26_s, br19_s;

    function automatic logic [4:0] alu_fs(input op_e op);
        case (op)
            OP_SUB, OP_SUBS, OP_SUBI: alu_fs = FS_SUB;
            OP_AND, OP_ANDI:          alu_fs = FS_AND;
            OP_ORR, OP_ORRI:          alu_fs = FS_ORR;
            default:                  alu_fs = FS_ADD;
        endcase
    endfunction

    // vcnz is the registered {V,C,N,Z} flag set
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] vcnz);
        logic v, c, n, z;
        {v, c, n, z} = vcnz;
        case (cond)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = ~z;
            4'h2:    cond_pass = c;
            4'h3:    cond_pass = ~c;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = ~n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = ~v;
            4'h8:    cond_pass = c & ~z;
            4'h9:    cond_pass = ~(c & ~z);
            4'hA:    cond_pass = (n == v);
            4'hB:    cond_pass = (n != v);
            4'hC:    cond_pass = ~z & (n == v);
            4'hD:    cond_pass = ~(~z & (n == v));
            default: cond_pass = 1'b1;
        endcase
    endfunction

    assign rd_s    = ir_q[4:0];
    assign rn_s    = ir_q[9:5];
    assign rm_s    = ir_q[20:16];
    assign imm12_s = {52'd0, ir_q[21:10]};
    assign imm9_s  = {{55{ir_q[20]}}, ir_q[20:12]};
    assign br26_s  = {{36{ir_q[25]}}, ir_q[25:0], 2'b00};
    assign br19_s  = {{43{ir_q[23]}}, ir_q[23:5], 2'b00};

`ifdef LEGV8_MOVZ_EN
    logic [63:0] movz_k_s;
    assign movz_k_s = {48'd0, ir_q[20:5]} << {ir_q[22:21], 4'b0000};
`endif

    // Opcode classification of the latched instruction.
    always_comb begin
        op_s = OP_BAD;
        casez (ir_q[31:21])
            11'b10001011000: op_s = OP_ADD;
            11'b11001011000: op_s = OP_SUB;
            11'b10001010000: op_s = OP_AND;
            11'b10101010000: op_s = OP_ORR;
            11'b10101011000: op_s = OP_ADDS;
            11'b11101011000: op_s = OP_SUBS;
            11'b1001000100?: op_s = OP_ADDI;
            11'b1101000100?: op_s = OP_SUBI;
            11'b1001001000?: op_s = OP_ANDI;
            11'b1011001000?: op_s = OP_ORRI;
            11'b11111000000: op_s = OP_STUR;
            11'b11111000010: op_s = OP_LDUR;
            11'b000101?????: op_s = OP_B;
            11'b100101?????: op_s = OP_BL;
            11'b11010110000: op_s = OP_BR;
            11'b10110100???: op_s = OP_CBZ;
            11'b10110101???: op_s = OP_CBNZ;
            11'b01010100???: op_s = OP_BCOND;
`ifdef LEGV8_MOVZ_EN
            11'b110100101??: op_s = OP_MOVZ;
`endif
            default:         op_s = OP_BAD;
        endcase
    end

    // Next-state and control-word generation.
    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        da_s          = 5'd0;
        sa_s          = 5'd0;
        sb_s          = 5'd0;
        fs_s          = 5'd0;
        bsel_s        = 1'b0;
        asel_s        = 1'b0;
        reg_write_s   = 1'b0;
        mem_write_s   = 1'b0;
        status_load_s = 1'b0;
        en_b_s        = 1'b0;
        en_alu_s      = 1'b0;
        en_mem_s      = 1'b0;
        en_pc_s       = 1'b0;
        ps_s          = 2'b00;
        k_s           = 64'd0;
        case (state_q)
            ST_FETCH: begin
                ir_d    = bus.instr;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (op_s)
                    OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDS, OP_SUBS: begin
                        da_s          = rd_s;
                        sa_s          = rn_s;
                        sb_s          = rm_s;
                        fs_s          = alu_fs(op_s);
                        reg_write_s   = 1'b1;
                        status_load_s = (op_s == OP_ADDS) || (op_s == OP_SUBS);
                        en_alu_s      = 1'b1;
                        ps_s          = 2'b01;
                    end
                    OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI: begin
                        da_s        = rd_s;
                        sa_s        = rn_s;
                        fs_s        = alu_fs(op_s);
                        bsel_s      = 1'b1;
                        k_s         = imm12_s;
                        reg_write_s = 1'b1;
                        en_alu_s    = 1'b1;
                        ps_s        = 2'b01;
                    end
                    // Store data rides the bus from register B; the ALU only forms the address.
                    OP_STUR: begin
                        sa_s        = rn_s;
                        sb_s        = rd_s;
                        fs_s        = FS_ADD;
                        bsel_s      = 1'b1;
                        k_s         = imm9_s;
                        mem_write_s = 1'b1;
                        en_b_s      = 1'b1;
                        ps_s        = 2'b01;
                    end
                    OP_LDUR: begin
                        sa_s     = rn_s;
                        fs_s     = FS_ADD;
                        bsel_s   = 1'b1;
                        k_s      = imm9_s;
                        en_alu_s = 1'b1;
                        state_d  = ST_WB;
                    end
                    OP_B: begin
                        asel_s   = 1'b1;
                        k_s      = br26_s;
                        en_alu_s = 1'b1;
                        ps_s     = 2'b10;
                    end
                    OP_BL: begin
                        da_s        = 5'd30;
                        asel_s      = 1'b1;
                        k_s         = br26_s;
                        reg_write_s = 1'b1;
                        en_pc_s     = 1'b1;
                        ps_s        = 2'b10;
                    end
                    OP_BR: begin
                        sa_s     = rn_s;
                        en_alu_s = 1'b1;
                        ps_s     = 2'b11;
                    end
                    OP_CBZ, OP_CBNZ: begin
                        sa_s     = rd_s;
                        sb_s     = 5'd31;
                        fs_s     = FS_ADD;
                        asel_s   = 1'b1;
                        k_s      = br19_s;
                        en_alu_s = 1'b1;
                        ps_s     = ((op_s == OP_CBZ) == bus.status_sig[0]) ? 2'b10 : 2'b01;
                    end
                    OP_BCOND: begin
                        asel_s   = 1'b1;
                        k_s      = br19_s;
                        en_alu_s = 1'b1;
                        ps_s     = cond_pass(ir_q[3:0], bus.status_sig[4:1]) ? 2'b10 : 2'b01;
                    end
                    OP_MOVZ: begin
`ifdef LEGV8_MOVZ_EN
                        da_s        = rd_s;
                        sb_s        = 5'd31;
                        fs_s        = FS_ORR;
                        bsel_s      = 1'b1;
                        k_s         = movz_k_s;
                        reg_write_s = 1'b1;
                        en_alu_s    = 1'b1;
                        ps_s        = 2'b01;
`else
                        state_d = ST_HALT;
`endif
                    end
                    default: state_d = ST_HALT;
                endcase
            end
            ST_WB: begin
                da_s        = rd_s;
                sa_s        = rn_s;
                fs_s        = FS_ADD;
                bsel_s      = 1'b1;
                k_s         = imm9_s;
                reg_write_s = 1'b1;
                en_mem_s    = 1'b1;
                ps_s        = 2'b01;
                state_d     = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    // An instruction retires on the cycle that moves the PC.
    always_comb begin
        if (ps_s != 2'b00) begin
            retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retired_d = retired_q;
        end
    end

    // State, instruction register and retire counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            ir_q      <= 32'd0;
            retired_q <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    assign bus.controlWord = {da_s, sa_s, sb_s, fs_s, bsel_s, asel_s, reg_write_s, mem_write_s,
                              status_load_s, en_b_s, en_alu_s, en_mem_s, en_pc_s, ps_s};
    assign bus.K       = k_s;
    assign bus.halted  = (state_q == ST_HALT);
    assign bus.retired = retired_q;

endmodule

// File: tb/tb_legv8_control_fsm.sv
// Bench for legv8_control_fsm: directed vector table, reset corner cases and
// randomized instructions checked against an instruction-level reference model.
module tb_legv8_control_fsm;

    localparam int CW = 8;

    logic clock;
    logic reset;

    legv8_control_fsm_if #(.CNT_W(CW)) bus ();

    legv8_control_fsm #(.CNT_W(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int exp_ret  = 0;

    typedef struct {
        logic [31:0] ins;
        logic [4:0]  st;
        logic [30:0] cw;
        logic [63:0] k;
        int          nxt;   // 0 back to fetch, 1 write-back cycle, 2 halt
        logic [30:0] wcw;
    } vec_t;

    vec_t        tbl [18];
    logic [10:0] r_ops [6];
    logic [9:0]  i_ops [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Field order follows the controlWord port description.
    function automatic logic [30:0] pk(input int da, input int sa, input int sb, input int fs,
                                       input int bsel, input int asel, input int rw, input int mw,
                                       input int sl, input int enb, input int enalu, input int enmem,
                                       input int enpc, input int ps);
        return {5'(da), 5'(sa), 5'(sb), 5'(fs), 1'(bsel), 1'(asel), 1'(rw), 1'(mw),
                1'(sl), 1'(enb), 1'(enalu), 1'(enmem), 1'(enpc), 2'(ps)};
    endfunction

    // Reference model: expected EXEC/WB behaviour of one instruction.
    function automatic void model(input logic [31:0] in, input logic [4:0] st,
                                  output logic [30:0] ecw, output logic [63:0] ek,
                                  output int nxt, output logic [30:0] wcw);
        logic [10:0] o11;
        int rd, rn, rm, cnd, fs;
        longint s9, s19, s26;
        logic v, c, n, z, base, taken;
        o11 = in[31:21];
        rd  = int'(in[4:0]);
        rn  = int'(in[9:5]);
        rm  = int'(in[20:16]);
        cnd = int'(in[3:0]);
        s9  = $signed(in[20:12]);
        s19 = $signed(in[23:5]);
        s26 = $signed(in[25:0]);
        {v, c, n, z} = st[4:1];
        case (cnd >> 1)
            0: base = z;
            1: base = c;
            2: base = n;
            3: base = v;
            4: base = c && !z;
            5: base = (n == v);
            6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        taken = (cnd >= 14) ? 1'b1 : (base ^ in[0]);
        ecw = 31'd0; ek = 64'd0; nxt = 0; wcw = 31'd0;
        if (o11 inside {11'h458, 11'h658, 11'h450, 11'h550, 11'h558, 11'h758}) begin
            case (o11)
                11'h458, 11'h558: fs = 8;
                11'h658, 11'h758: fs = 11;
                11'h450:          fs = 0;
                default:          fs = 4;
            endcase
            ecw = pk(rd, rn, rm, fs, 0, 0, 1, 0, (o11 == 11'h558 || o11 == 11'h758) ? 1 : 0,
                     0, 1, 0, 0, 1);
        end else if (in[31:22] inside {10'h244, 10'h344, 10'h248, 10'h2C8}) begin
            case (in[31:22])
                10'h244: fs = 8;
                10'h344: fs = 11;
                10'h248: fs = 0;
                default: fs = 4;
            endcase
            ecw = pk(rd, rn, 0, fs, 1, 0, 1, 0, 0, 0, 1, 0, 0, 1);
            ek  = 64'(in[21:10]);
        end else if (o11 == 11'h7C0) begin
            ecw = pk(0, rn, rd, 8, 1, 0, 0, 1, 0, 1, 0, 0, 0, 1);
            ek  = s9;
        end else if (o11 == 11'h7C2) begin
            ecw = pk(0, rn, 0, 8, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
            wcw = pk(rd, rn, 0, 8, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1);
            ek  = s9;
            nxt = 1;
        end else if (in[31:26] == 6'b000101) begin
            ecw = pk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 2);
            ek  = s26 * 4;
        end else if (in[31:26] == 6'b100101) begin
            ecw = pk(30, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 2);
            ek  = s26 * 4;
        end else if (o11 == 11'h6B0) begin
            ecw = pk(0, rn, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3);
        end else if (in[31:25] == 7'b1011010) begin
            ecw = pk(0, rd, 31, 8, 0, 1, 0, 0, 0, 0, 1, 0, 0,
                     ((in[24] == 1'b0) == (st[0] == 1'b1)) ? 2 : 1);
            ek  = s19 * 4;
        end else if (in[31:24] == 8'h54) begin
            ecw = pk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, taken ? 2 : 1);
            ek  = s19 * 4;
`ifdef LEGV8_MOVZ_EN
        end else if (in[31:23] == 9'h1A5) begin
            ecw = pk(rd, 0, 31, 4, 1, 0, 1, 0, 0, 0, 1, 0, 0, 1);
            ek  = 64'(in[20:5]) << (16 * int'(in[22:21]));
`endif
        end else begin
            nxt = 2;
        end
    endfunction

    function automatic logic [31:0] gen(input int cls);
        logic [31:0] r;
        r = $urandom;
        case (cls)
            0:       return {r_ops[$urandom_range(0, 5)], r[20:0]};
            1:       return {i_ops[$urandom_range(0, 3)], r[21:0]};
            2:       return {11'h7C0, r[20:0]};
            3:       return {11'h7C2, r[20:0]};
            4:       return {6'b000101, r[25:0]};
            5:       return {6'b100101, r[25:0]};
            6:       return {11'h6B0, r[20:0]};
            7:       return {8'hB4, r[23:0]};
            8:       return {8'hB5, r[23:0]};
            9:       return {8'h54, r[23:0]};
            default: return {9'h1A5, r[22:0]};
        endcase
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("reset_cw", 64'(bus.controlWord), 64'd0);
        chk("reset_retired", 64'(bus.retired), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        exp_ret = 0;
    endtask

    // Entered and left #1 after a rising edge with the DUT in FETCH.
    task automatic run(input logic [31:0] ins, input logic [4:0] st, input logic [30:0] ecw,
                       input logic [63:0] ek, input int nxt, input logic [30:0] wcw);
        bus.instr      = ins;
        bus.status_sig = 5'($urandom);
        #1;
        chk("fetch_cw", 64'(bus.controlWord), 64'd0);
        chk("fetch_k", bus.K, 64'd0);
        @(posedge clock);
        #1;
        bus.instr      = $urandom;
        bus.status_sig = st;
        #1;
        chk("exec_cw", 64'(bus.controlWord), 64'(ecw));
        chk("exec_k", bus.K, ek);
        chk("exec_halted", 64'(bus.halted), 64'd0);
        @(posedge clock);
        #1;
        if (nxt == 1) begin
            bus.status_sig = 5'($urandom);
            #1;
            chk("wb_cw", 64'(bus.controlWord), 64'(wcw));
            chk("wb_k", bus.K, ek);
            chk("wb_retired", 64'(bus.retired), 64'(exp_ret));
            @(posedge clock);
            #1;
        end
        if (nxt == 2) begin
            for (int j = 0; j < 3; j++) begin
                bus.instr = $urandom;
                #1;
                chk("halt_flag", 64'(bus.halted), 64'd1);
                chk("halt_cw", 64'(bus.controlWord), 64'd0);
                chk("halt_retired", 64'(bus.retired), 64'(exp_ret));
                @(posedge clock);
                #1;
            end
            do_reset();
        end else begin
            exp_ret = (exp_ret + 1) % (1 << CW);
            chk("retired", 64'(bus.retired), 64'(exp_ret));
        end
    endtask

    initial begin
        logic [31:0] ins;
        logic [4:0]  st;
        logic [30:0] ecw, wcw;
        logic [63:0] ek;
        int          nx;
        int          ncls;

        r_ops = '{11'h458, 11'h658, 11'h450, 11'h550, 11'h558, 11'h758};
        i_ops = '{10'h244, 10'h344, 10'h248, 10'h2C8};

        tbl[0]  = '{32'h910017E1, 5'b00000, pk(1, 31, 0, 8, 1, 0, 1, 0, 0, 0, 1, 0, 0, 1), 64'd5, 0, 31'd0};
        tbl[1]  = '{32'h54000040, 5'b00010, pk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 2), 64'd8, 0, 31'd0};
        tbl[2]  = '{32'h54000040, 5'b11101, pk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1), 64'd8, 0, 31'd0};
        tbl[3]  = '{32'hB4FFFFE2, 5'b00001, pk(0, 2, 31, 8, 0, 1, 0, 0, 0, 0, 1, 0, 0, 2), 64'hFFFF_FFFF_FFFF_FFFC, 0, 31'd0};
        tbl[4]  = '{32'hB4FFFFE2, 5'b11110, pk(0, 2, 31, 8, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1), 64'hFFFF_FFFF_FFFF_FFFC, 0, 31'd0};
        tbl[5]  = '{32'hB5FFFFE2, 5'b00000, pk(0, 2, 31, 8, 0, 1, 0, 0, 0, 0, 1, 0, 0, 2), 64'hFFFF_FFFF_FFFF_FFFC, 0, 31'd0};
        tbl[6]  = '{32'hF8408083, 5'b00000, pk(0, 4, 0, 8, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0), 64'd8, 1,
                    pk(3, 4, 0, 8, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1)};
        tbl[7]  = '{32'hF81F80C5, 5'b00000, pk(0, 6, 5, 8, 1, 0, 0, 1, 0, 1, 0, 0, 0, 1), 64'hFFFF_FFFF_FFFF_FFF8, 0, 31'd0};
        tbl[8]  = '{32'h94000001, 5'b00000, pk(30, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 2), 64'd4, 0, 31'd0};
        tbl[9]  = '{32'hD61F03C0, 5'b00000, pk(0, 30, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3), 64'd0, 0, 31'd0};
        tbl[10] = '{32'hEB020023, 5'b00000, pk(3, 1, 2, 11, 0, 0, 1, 0, 1, 0, 1, 0, 0, 1), 64'd0, 0, 31'd0};
        tbl[11] = '{32'h5400004C, 5'b10100, pk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 2), 64'd8, 0, 31'd0};
        tbl[12] = '{32'h5400004D, 5'b10100, pk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1), 64'd8, 0, 31'd0};
        tbl[13] = '{32'h5400004F, 5'b00000, pk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 2), 64'd8, 0, 31'd0};
        tbl[14] = '{32'h17FFFFFF, 5'b00000, pk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 2), 64'hFFFF_FFFF_FFFF_FFFC, 0, 31'd0};
        tbl[15] = '{32'hB23FFD07, 5'b00000, pk(7, 8, 0, 4, 1, 0, 1, 0, 0, 0, 1, 0, 0, 1), 64'hFFF, 0, 31'd0};
        tbl[16] = '{32'h00000000, 5'b00000, 31'd0, 64'd0, 2, 31'd0};
`ifdef LEGV8_MOVZ_EN
        tbl[17] = '{32'hD2A24685, 5'b00000, pk(5, 0, 31, 4, 1, 0, 1, 0, 0, 0, 1, 0, 0, 1), 64'h1234_0000, 0, 31'd0};
        ncls = 11;
`else
        tbl[17] = '{32'hD2A24685, 5'b00000, 31'd0, 64'd0, 2, 31'd0};
        ncls = 10;
`endif

        reset          = 1'b0;
        bus.instr      = 32'h910017E1;
        bus.status_sig = 5'd0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_cw", 64'(bus.controlWord), 64'd0);
        chk("rst_k", bus.K, 64'd0);
        chk("rst_halted", 64'(bus.halted), 64'd0);
        chk("rst_retired", 64'(bus.retired), 64'd0);
        reset = 1'b1;

        for (int i = 0; i < 18; i++) begin
            run(tbl[i].ins, tbl[i].st, tbl[i].cw, tbl[i].k, tbl[i].nxt, tbl[i].wcw);
        end

        // Reset asserted while a store is in EXEC must kill the write immediately.
        bus.instr = 32'hF81F80C5;
        @(posedge clock);
        #2;
        chk("stur_exec_cw", 64'(bus.controlWord), 64'(pk(0, 6, 5, 8, 1, 0, 0, 1, 0, 1, 0, 0, 0, 1)));
        reset = 1'b0;
        #1;
        chk("midrst_cw", 64'(bus.controlWord), 64'd0);
        chk("midrst_retired", 64'(bus.retired), 64'd0);
        chk("midrst_halted", 64'(bus.halted), 64'd0);
        bus.instr = 32'h910017E1;
        @(posedge clock);
        #1;
        reset = 1'b1;
        exp_ret = 0;
        #1;
        chk("post_rst_cw", 64'(bus.controlWord), 64'd0);
        @(posedge clock);
        #2;
        chk("post_rst_exec", 64'(bus.controlWord), 64'(pk(1, 31, 0, 8, 1, 0, 1, 0, 0, 0, 1, 0, 0, 1)));
        @(posedge clock);
        #1;
        exp_ret = 1;
        chk("post_rst_retired", 64'(bus.retired), 64'(exp_ret));

        // Long random run also carries the narrow retire counter through its wrap.
        for (int i = 0; i < 320; i++) begin
            ins = gen($urandom_range(0, ncls - 1));
            st  = 5'($urandom);
            model(ins, st, ecw, ek, nx, wcw);
            run(ins, st, ecw, ek, nx, wcw);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
